// File: rtl/mul_iter_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiplier.
// The master side is the pipeline; the slave side is the multiplier itself.
interface mul_iter_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic             flush_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;

    modport master (
        output start_i, flush_i, data1_i, data2_i,
        input  data_o, zero_o, busy_o, done_o, stall_o
    );

    modport slave (
        input  start_i, flush_i, data1_i, data2_i,
        output data_o, zero_o, busy_o, done_o, stall_o
    );
endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for the EX stage. Produces the low WIDTH
// bits of data1*data2 after a fixed WIDTH-cycle run, stalling the front of
// the pipeline until the result is registered.
module mul_iter_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input logic          clk_i,
    input logic          rst_i,
    mul_iter_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   acc_step;
    logic               accept;

    assign accept   = bus.start_i & ~bus.flush_i;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

    // Next-state and datapath step; flush overrides everything but leaves data intact.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;

        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mcand_d  = bus.data1_i;
                        mplier_d = bus.data2_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        data_d  = acc_step;
                        state_d = S_DONE;
                    end
                end
                // start_i is still high for the finishing instruction; do not restart.
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from state; stall covers the accept cycle combinationally.
    always_comb begin
        bus.data_o  = data_q;
        bus.zero_o  = (data_q == '0);
        bus.busy_o  = (state_q == S_RUN);
        bus.done_o  = (state_q == S_DONE);
        bus.stall_o = ((state_q == S_IDLE) & accept) | (state_q == S_RUN);
    end

endmodule
